// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 16;
  localparam int unsigned SRAM_ADDR_WIDTH = 8;
  localparam int unsigned STRB_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is a combinational one-hot view of
// who would win now; the last_grant flop only moves when the grant is used.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of each accepted grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_en && (grant != 2'b00)) begin
      last_grant_d = grant[1];
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Shares one asynchronous single-port SRAM between instruction fetch (0) and
// load/store (1). Each access is a SETUP / STROBE / HOLD sequence on the pins;
// every SRAM-facing output comes straight from a flop.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = SRAM_ADDR_WIDTH,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0]      sram_address,
  inout  logic [DATA_WIDTH-1:0]      sram_data,
  output logic                       sram_chip_enable,
  output logic                       sram_write_enable,
  output logic                       sram_output_enable,
  output logic                       sram_reset
);

  state_e                    state_q, state_d;
  logic [STRB_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      wr_q, wr_d;
  logic                      gnt_idx_q, gnt_idx_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      drive_q, drive_d;
  logic                      ce_n_q, ce_n_d;
  logic                      we_n_q, we_n_d;
  logic                      oe_n_q, oe_n_d;
  logic [1:0]                rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      sram_reset_q, sram_reset_d;

  logic [1:0] grant;
  logic       handshake;
  logic       gidx;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .grant_en (handshake),
    .grant    (grant)
  );

  // Ready only in IDLE and out of reset, on the requester the arbiter picks.
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !reset) begin
      req_ready = grant;
    end
    handshake = |(req_valid & req_ready);
    gidx      = req_ready[1];
  end

  // Next-state and next-pin computation; pins for a phase are set on the
  // edge that enters it so the outputs stay glitch-free flop outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    gnt_idx_d    = gnt_idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    drive_d      = drive_q;
    ce_n_d       = ce_n_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    rsp_valid_d  = '0;
    rdata_d      = rdata_q;
    sram_reset_d = reset;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = SETUP;
          gnt_idx_d = gidx;
          wr_d      = req_write[gidx];
          addr_d    = req_addr[gidx];
          wdata_d   = req_wdata[gidx];
          drive_d   = req_write[gidx];
          ce_n_d    = 1'b0;
          we_n_d    = 1'b1;
          oe_n_d    = 1'b1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = STRB_CNT_WIDTH'(STROBE_CYCLES - 1);
        we_n_d  = !wr_q;
        oe_n_d  = wr_q;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d                = HOLD;
          we_n_d                 = 1'b1;
          oe_n_d                 = 1'b1;
          rsp_valid_d[gnt_idx_q] = 1'b1;
          if (!wr_q) begin
            rdata_d = sram_data;
          end
        end else begin
          cnt_d = cnt_q - STRB_CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pin registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    sram_reset_q <= sram_reset_d;
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      gnt_idx_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      gnt_idx_q   <= gnt_idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign sram_data          = drive_q ? wdata_q : 'z;
  assign sram_address       = addr_q;
  assign sram_chip_enable   = ce_n_q;
  assign sram_write_enable  = we_n_q;
  assign sram_output_enable = oe_n_q;
  assign sram_reset         = sram_reset_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (strobe length 2 and 1), each
// with a behavioural asynchronous SRAM that reloads an init image on
// sram_reset and writes on every clock edge while CE and WE are low.
module tb_sram_access_ctrl;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       req_valid [2];
  logic [1:0]       req_write [2];
  logic [1:0][7:0]  req_addr  [2];
  logic [1:0][15:0] req_wdata [2];
  logic [1:0]       req_ready [2];
  logic [1:0]       rsp_valid [2];
  logic [15:0]      rsp_rdata [2];
  logic [7:0]       sram_address [2];
  logic             ce_n [2];
  logic             we_n [2];
  logic             oe_n [2];
  logic             srst [2];
  wire  [15:0]      sram_data0;
  wire  [15:0]      sram_data1;

  logic [15:0] mem [2][256];

  sram_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .STROBE_CYCLES(S0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_address(sram_address[0]), .sram_data(sram_data0),
    .sram_chip_enable(ce_n[0]), .sram_write_enable(we_n[0]),
    .sram_output_enable(oe_n[0]), .sram_reset(srst[0])
  );

  sram_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .STROBE_CYCLES(S1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_address(sram_address[1]), .sram_data(sram_data1),
    .sram_chip_enable(ce_n[1]), .sram_write_enable(we_n[1]),
    .sram_output_enable(oe_n[1]), .sram_reset(srst[1])
  );

  // Init image loaded by the SRAM whenever its reset pin is high.
  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'd50:   return 16'h0073;
      8'd124:  return 16'h3779;
      8'd242:  return 16'h0078;
      default: return {~a, a};
    endcase
  endfunction

  function automatic logic [15:0] bus(input int k);
    return (k == 0) ? sram_data0 : sram_data1;
  endfunction

  assign sram_data0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem[0][sram_address[0]] : 16'bz;
  assign sram_data1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem[1][sram_address[1]] : 16'bz;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (srst[k]) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_word(8'(a));
      end else if (!ce_n[k] && !we_n[k]) begin
        mem[k][sram_address[k]] <= bus(k);
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] prev_addr [2];
  logic       prev_ce [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next sampling point and check the pin invariants.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      chk("inv_we_oe_both_low", 64'(!we_n[k] && !oe_n[k]), 64'd0);
      chk("inv_rsp_onehot", 64'($countones(rsp_valid[k]) > 1), 64'd0);
      chk("inv_addr_stable", 64'((sram_address[k] != prev_addr[k]) && !prev_ce[k] && !reset), 64'd0);
      prev_addr[k] = sram_address[k];
      prev_ce[k]   = ce_n[k];
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) req_valid[k] = 2'b11;
    reset = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 64'(req_ready[k]), 64'd0);
      chk("rst_enables", 64'({ce_n[k], we_n[k], oe_n[k]}), 64'b111);
      chk("rst_addr", 64'(sram_address[k]), 64'd0);
      chk("rst_rsp", 64'(rsp_valid[k]), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata[k]), 64'd0);
      chk("rst_sram_reset", 64'(srst[k]), 64'd1);
      req_valid[k] = 2'b00;
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("sram_reset_tail", 64'(srst[k]), 64'd1);
    step();
    for (int k = 0; k < 2; k++) chk("sram_reset_fall", 64'(srst[k]), 64'd0);
  endtask

  // One complete access from an otherwise idle controller; checks the pin
  // waveform cycle by cycle against the SETUP/STROBE/HOLD timing.
  task automatic access(input int k, input int idx, input bit wr, input logic [7:0] a,
                        input logic [15:0] d, input string nm, output int hs_cyc);
    int s;
    int w;
    s = (k == 0) ? S0 : S1;
    req_write[k][idx] = wr;
    req_addr[k][idx]  = a;
    req_wdata[k][idx] = d;
    req_valid[k][idx] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[k][idx] && w < 40) begin
      step();
      #1;
      w++;
    end
    chk({nm, " ready_wait"}, 64'(w), 64'd0);
    hs_cyc = cyc;
    if (!req_ready[k][idx]) begin
      req_valid[k][idx] = 1'b0;
      return;
    end
    for (int c = 1; c <= s + 3; c++) begin
      logic       strobe;
      logic [4:0] e;
      logic [4:0] g;
      step();
      if (c == 1) req_valid[k][idx] = 1'b0;
      strobe = (c >= 2) && (c <= s + 1);
      e = {c == s + 3, !(wr && strobe), !(!wr && strobe),
           (c == s + 2) ? 2'(1 << idx) : 2'b00};
      g = {ce_n[k], we_n[k], oe_n[k], rsp_valid[k]};
      chk({nm, " pins"}, 64'(g), 64'(e));
      if (c <= s + 2) chk({nm, " addr"}, 64'(sram_address[k]), 64'(a));
      if (wr && strobe) chk({nm, " bus"}, 64'(bus(k)), 64'(d));
      if ((c == s + 2) && !wr) chk({nm, " rdata"}, 64'(rsp_rdata[k]), 64'(d));
    end
  endtask

  typedef struct {
    int          k;
    int          idx;
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;    // write data, or expected read data
    bit          b2b;  // must start exactly one access period after the previous
  } vec_t;

  typedef struct {
    int          due;
    int          idx;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  initial begin
    vec_t        tbl [15];
    int          hs;
    int          prev_hs;
    int          last_rsp;
    int          w;
    logic [15:0] shadow [256];
    exp_t        eq [$];
    exp_t        ev;
    bit          pend [2];
    int          busy;
    int          g;
    bit          last;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_v;

    tbl[0]  = '{0, 0, 1'b0, 8'd50,  16'h0073, 1'b0};
    tbl[1]  = '{0, 1, 1'b0, 8'd124, 16'h3779, 1'b0};
    tbl[2]  = '{0, 0, 1'b0, 8'd242, 16'h0078, 1'b0};
    tbl[3]  = '{0, 0, 1'b1, 8'h32,  16'hBEEF, 1'b0};
    tbl[4]  = '{0, 1, 1'b0, 8'h32,  16'hBEEF, 1'b0};
    tbl[5]  = '{0, 0, 1'b0, 8'h32,  16'hBEEF, 1'b0};
    tbl[6]  = '{0, 0, 1'b0, 8'h10,  16'hEF10, 1'b0};
    tbl[7]  = '{1, 0, 1'b1, 8'hFF,  16'hA5F0, 1'b0};
    tbl[8]  = '{1, 1, 1'b1, 8'h00,  16'h1357, 1'b1};
    tbl[9]  = '{1, 0, 1'b1, 8'h80,  16'h8001, 1'b1};
    tbl[10] = '{1, 1, 1'b1, 8'h01,  16'hFFFF, 1'b1};
    tbl[11] = '{1, 0, 1'b0, 8'hFF,  16'hA5F0, 1'b1};
    tbl[12] = '{1, 0, 1'b0, 8'h00,  16'h1357, 1'b1};
    tbl[13] = '{1, 1, 1'b0, 8'h80,  16'h8001, 1'b1};
    tbl[14] = '{1, 1, 1'b0, 8'h01,  16'hFFFF, 1'b1};

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0;
      req_write[k] = '0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      prev_addr[k] = '0;
      prev_ce[k]   = 1'b1;
    end

    // Reset state, then the vector table.
    do_reset();
    prev_hs = -100;
    for (int i = 0; i < 15; i++) begin
      access(tbl[i].k, tbl[i].idx, tbl[i].wr, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i), hs);
      if (tbl[i].b2b) chk($sformatf("vec%0d period", i), 64'(hs - prev_hs),
                          64'((tbl[i].k == 0 ? S0 : S1) + 3));
      prev_hs = hs;
    end

    // Both requesters permanently valid: strict alternation starting at 0.
    do_reset();
    req_write[0] = 2'b00;
    req_addr[0][0] = 8'd50;
    req_addr[0][1] = 8'd124;
    req_valid[0] = 2'b11;
    last_rsp = 0;
    for (int n = 0; n < 6; n++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (rsp_valid[0] == 2'b00 && w < 50);
      chk("rr_order", 64'(rsp_valid[0]), (n % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr_rdata", 64'(rsp_rdata[0]), (n % 2 == 0) ? 64'h0073 : 64'h3779);
      if (n > 0) chk("rr_period", 64'(cyc - last_rsp), 64'(S0 + 3));
      last_rsp = cyc;
      if (n == 5) req_valid[0] = 2'b00;
    end
    repeat (6) step();

    // Reset during the second strobe cycle of a write; the held request
    // must be regranted afterwards and complete normally.
    req_write[0][0] = 1'b1;
    req_addr[0][0]  = 8'd7;
    req_wdata[0][0] = 16'h1234;
    req_valid[0]    = 2'b01;
    #1;
    chk("mr_ready", 64'(req_ready[0]), 64'b01);
    repeat (3) step();
    chk("mr_strobe", 64'({ce_n[0], we_n[0], oe_n[0]}), 64'b001);
    reset = 1'b1;
    step();
    chk("mr_abort_pins", 64'({ce_n[0], we_n[0], oe_n[0], rsp_valid[0]}), 64'b11100);
    chk("mr_ready_in_reset", 64'(req_ready[0]), 64'd0);
    reset = 1'b0;
    #1;
    chk("mr_sram_reset", 64'(srst[0]), 64'd1);
    chk("mr_regrant", 64'(req_ready[0]), 64'b01);
    access(0, 0, 1'b1, 8'd7, 16'h1234, "mr_write", hs);
    access(0, 1, 1'b0, 8'd7, 16'h1234, "mr_readback", hs);

    // Randomised traffic against a transaction-level model: one access at a
    // time, each occupying S+3 cycles, response S+2 cycles after acceptance.
    do_reset();
    for (int a = 0; a < 256; a++) shadow[a] = init_word(8'(a));
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    busy = 0;
    last = 1'b1;
    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (it < 500 && $urandom_range(0, 2) != 0) begin
            pend[i] = 1'b1;
            req_write[0][i] = 1'($urandom_range(0, 1));
            req_addr[0][i]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            req_wdata[0][i] = 16'($urandom);
            req_valid[0][i] = 1'b1;
          end else begin
            req_valid[0][i] = 1'b0;
          end
        end
      end
      #1;
      exp_rdy = 2'b00;
      g = 0;
      if (busy == 0 && (pend[0] || pend[1])) begin
        g = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
        exp_rdy = 2'(1 << g);
      end
      chk("rnd_ready", 64'(req_ready[0]), 64'(exp_rdy));
      exp_v = 2'b00;
      ev = '{0, 0, 1'b0, 16'h0};
      if (eq.size() > 0 && eq[0].due == cyc) begin
        ev = eq.pop_front();
        exp_v = 2'(1 << ev.idx);
      end
      chk("rnd_rsp", 64'(rsp_valid[0]), 64'(exp_v));
      if (ev.rd) chk("rnd_rdata", 64'(rsp_rdata[0]), 64'(ev.data));
      if (exp_rdy != 2'b00) begin
        eq.push_back('{cyc + S0 + 2, g, !req_write[0][g], shadow[req_addr[0][g]]});
        if (req_write[0][g]) shadow[req_addr[0][g]] = req_wdata[0][g];
        last = g[0];
        busy = S0 + 3;
        pend[g] = 1'b0;
      end
      if (busy > 0) busy--;
      step();
    end
    chk("rnd_drained", 64'(eq.size()), 64'd0);
    chk("rnd_all_served", 64'(pend[0] || pend[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
